// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side sequencer for the UART.
// Qualifies the start bit at mid-bit on the oversampled baud tick and
// drives load/shift into the RX shift register. It also checks the stop bit
// and holds a completed character for the host through a valid/ack handshake.
module uart_rx_ctrl #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic fsm_clk,
  input  logic fsm_rst_n,
  input  logic baud_tick,
  input  logic rxd_sync,
  input  logic data_ack,
  output logic load,
  output logic shift,
  output logic shift_bit,
  output logic busy,
  output logic data_valid,
  output logic frame_err,
  output logic overrun_err
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] START_LIM = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LIM   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state, state_nx;
  logic [TW-1:0] tick_cnt, tick_cnt_nx;
  logic [BW-1:0] bit_cnt, bit_cnt_nx;
  logic          load_nx, shift_nx, shift_bit_nx, valid_nx, ferr_nx, ovr_nx;

  // Next-state, counter and output decode; everything advances only on a baud tick.
  always_comb begin
    state_nx     = state;
    tick_cnt_nx  = tick_cnt;
    bit_cnt_nx   = bit_cnt;
    load_nx      = 1'b0;
    shift_nx     = 1'b0;
    shift_bit_nx = 1'b0;
    ferr_nx      = 1'b0;
    ovr_nx       = 1'b0;
    valid_nx     = data_valid & ~data_ack;
    if (baud_tick) begin
      case (state)
        IDLE: begin
          tick_cnt_nx = '0;
          if (!rxd_sync) state_nx = START;
        end
        START: begin
          if (tick_cnt == START_LIM) begin
            tick_cnt_nx = '0;
            if (!rxd_sync) begin
              state_nx   = DATA;
              bit_cnt_nx = '0;
              load_nx    = 1'b1;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            tick_cnt_nx = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == BIT_LIM) begin
            tick_cnt_nx  = '0;
            shift_nx     = 1'b1;
            shift_bit_nx = rxd_sync;
            bit_cnt_nx   = bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state_nx = STOP;
          end else begin
            tick_cnt_nx = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == BIT_LIM) begin
            tick_cnt_nx = '0;
            state_nx    = IDLE;
            if (rxd_sync) begin
              // A new set overrides a same-cycle ack, so only flag overrun
              // when the old character is still pending and not being taken.
              valid_nx = 1'b1;
              ovr_nx   = data_valid & ~data_ack;
            end else begin
              ferr_nx = 1'b1;
            end
          end else begin
            tick_cnt_nx = tick_cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge fsm_clk or negedge fsm_rst_n) begin
    if (!fsm_rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      load        <= 1'b0;
      shift       <= 1'b0;
      shift_bit   <= 1'b0;
      busy        <= 1'b0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_nx;
      tick_cnt    <= tick_cnt_nx;
      bit_cnt     <= bit_cnt_nx;
      load        <= load_nx;
      shift       <= shift_nx;
      shift_bit   <= shift_bit_nx;
      busy        <= (state_nx != IDLE);
      data_valid  <= valid_nx;
      frame_err   <= ferr_nx;
      overrun_err <= ovr_nx;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: drives serial frames tick by tick, predicts
// every output event from frame arithmetic, and checks in a separate monitor.
module tb_uart_rx_ctrl;

  localparam int unsigned DB    = 8;
  localparam int unsigned OS    = 16;
  localparam int unsigned HALF  = OS / 2;
  localparam int unsigned FRAME = HALF + (DB + 1) * OS;

  logic fsm_clk   = 1'b0;
  logic fsm_rst_n = 1'b0;
  logic baud_tick = 1'b0;
  logic rxd_sync  = 1'b1;
  logic data_ack  = 1'b0;
  logic load, shift, shift_bit, busy, data_valid, frame_err, overrun_err;

  typedef enum int {EV_BRISE, EV_LOAD, EV_SHIFT, EV_VRISE, EV_VFALL,
                    EV_FERR, EV_OVR, EV_BFALL} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int unsigned tick;
    logic        b;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned tick_total = 0;
  int unsigned div_cnt    = 0;
  int          n_tests    = 0;
  int          n_fail     = 0;
  bit          m_valid    = 1'b0;

  uart_rx_ctrl #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .fsm_clk(fsm_clk), .fsm_rst_n(fsm_rst_n), .baud_tick(baud_tick),
    .rxd_sync(rxd_sync), .data_ack(data_ack), .load(load), .shift(shift),
    .shift_bit(shift_bit), .busy(busy), .data_valid(data_valid),
    .frame_err(frame_err), .overrun_err(overrun_err)
  );

  always #5 fsm_clk = ~fsm_clk;

  // Baud tick every 4 clocks, changed on the falling edge.
  always @(negedge fsm_clk) begin
    div_cnt   <= (div_cnt + 1) % 4;
    baud_tick <= ((div_cnt + 1) % 4 == 0);
  end

  // Index of the most recent tick the DUT has sampled.
  always @(posedge fsm_clk) if (baud_tick) tick_total <= tick_total + 1;

  function automatic void push(input ev_kind_e k, input int unsigned t, input logic b);
    ev_t e;
    e.kind = k; e.tick = t; e.b = b;
    exp_q.push_back(e);
  endfunction

  // Reference: a frame detected at tick t0 produces its events at fixed offsets.
  function automatic void expect_frame(input int unsigned t0, input logic [DB-1:0] d,
                                       input logic stop, input logic ack, input int cut);
    int unsigned ts;
    push(EV_BRISE, t0, 1'b0);
    push(EV_LOAD, t0 + HALF, 1'b0);
    for (int k = 0; k < cut; k++) push(EV_SHIFT, t0 + HALF + (k + 1) * OS, d[k]);
    if (cut < DB) return;
    ts = t0 + FRAME;
    if (stop) begin
      if (!m_valid) push(EV_VRISE, ts, 1'b0);
      else if (!ack) push(EV_OVR, ts, 1'b0);
      m_valid = 1'b1;
    end else begin
      if (ack && m_valid) begin
        push(EV_VFALL, ts, 1'b0);
        m_valid = 1'b0;
      end
      push(EV_FERR, ts, 1'b0);
    end
    push(EV_BFALL, ts, 1'b0);
  endfunction

  task automatic check_lvl(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic observe(input ev_kind_e k, input logic b);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got %s tick %0d bit %0b, expected nothing", k.name(), tick_total, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.tick != tick_total || (k == EV_SHIFT && e.b !== b)) begin
        n_fail++;
        $display("FAIL event: got %s tick %0d bit %0b, expected %s tick %0d bit %0b",
                 k.name(), tick_total, b, e.kind.name(), e.tick, e.b);
      end
    end
  endtask

  // Monitor: every output presentation pops one expectation.
  initial begin : monitor
    logic pb, pv;
    pb = 1'b0; pv = 1'b0;
    forever begin
      @(negedge fsm_clk);
      if (!fsm_rst_n) begin
        pb = 1'b0; pv = 1'b0;
      end else begin
        if (busy && !pb)        observe(EV_BRISE, 1'b0);
        if (load)               observe(EV_LOAD, 1'b0);
        if (shift)              observe(EV_SHIFT, shift_bit);
        if (data_valid && !pv)  observe(EV_VRISE, 1'b0);
        if (!data_valid && pv)  observe(EV_VFALL, 1'b0);
        if (frame_err)          observe(EV_FERR, 1'b0);
        if (overrun_err)        observe(EV_OVR, 1'b0);
        if (!busy && pb)        observe(EV_BFALL, 1'b0);
        pb = busy; pv = data_valid;
      end
    end
  end

  initial begin : watchdog
    #600us;
    $display("FAIL watchdog: simulation did not complete, %0d expectations pending", exp_q.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  // Hold rxd for one tick; optionally raise data_ack only on that tick's clock.
  task automatic drive_tick(input logic v, input logic ack);
    rxd_sync = v;
    do begin
      @(negedge fsm_clk); #1;
    end while (!baud_tick);
    data_ack = ack;
    @(posedge fsm_clk); #1;
    data_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_tick(1'b1, 1'b0);
  endtask

  task automatic ack_clear();
    do begin
      @(negedge fsm_clk); #1;
    end while (baud_tick);
    data_ack = 1'b1;
    if (m_valid) push(EV_VFALL, tick_total, 1'b0);
    m_valid = 1'b0;
    @(posedge fsm_clk); #1;
    data_ack = 1'b0;
  endtask

  // cut < DB stops the line mid-way through data bit 'cut'.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop,
                            input logic ack_stop, input int cut);
    int unsigned t0;
    drive_tick(1'b0, 1'b0);
    t0 = tick_total;
    expect_frame(t0, d, stop, ack_stop, cut);
    repeat (OS - 1) drive_tick(1'b0, 1'b0);
    for (int k = 0; k < DB; k++) begin
      if (k == cut) begin
        repeat (HALF) drive_tick(d[k], 1'b0);
        return;
      end
      repeat (OS) drive_tick(d[k], 1'b0);
    end
    repeat (HALF) drive_tick(stop, 1'b0);
    drive_tick(stop, ack_stop);
    repeat (OS - HALF - 1) drive_tick(1'b1, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_lvl({tag, " load"}, load, 1'b0);
    check_lvl({tag, " shift"}, shift, 1'b0);
    check_lvl({tag, " shift_bit"}, shift_bit, 1'b0);
    check_lvl({tag, " busy"}, busy, 1'b0);
    check_lvl({tag, " data_valid"}, data_valid, 1'b0);
    check_lvl({tag, " frame_err"}, frame_err, 1'b0);
    check_lvl({tag, " overrun_err"}, overrun_err, 1'b0);
  endtask

  initial begin : stim
    int unsigned t0;
    logic [DB-1:0] d;
    logic st;

    fsm_rst_n = 1'b0;
    repeat (3) @(posedge fsm_clk);
    #1;
    check_all_zero("reset");
    fsm_rst_n = 1'b1;
    idle(5);

    // Nominal frame.
    send_frame(8'hA5, 1'b1, 1'b0, DB);
    check_lvl("valid after A5", data_valid, m_valid);
    ack_clear();
    idle(3);
    ack_clear();  // ack with nothing pending is ignored

    // Short low glitch aborts at mid start bit.
    drive_tick(1'b0, 1'b0);
    t0 = tick_total;
    push(EV_BRISE, t0, 1'b0);
    push(EV_BFALL, t0 + HALF, 1'b0);
    drive_tick(1'b0, 1'b0);
    drive_tick(1'b0, 1'b0);
    idle(HALF + 4);
    check_lvl("valid after glitch", data_valid, 1'b0);

    // Framing error.
    send_frame(8'h3C, 1'b0, 1'b0, DB);
    check_lvl("valid after ferr", data_valid, 1'b0);
    idle(4);

    // Back-to-back without ack: overrun.
    send_frame(8'h11, 1'b1, 1'b0, DB);
    send_frame(8'h22, 1'b1, 1'b0, DB);
    check_lvl("valid after overrun", data_valid, 1'b1);
    ack_clear();
    idle(4);

    // Back-to-back with ack on the second set: set wins, no overrun.
    send_frame(8'h11, 1'b1, 1'b0, DB);
    send_frame(8'h22, 1'b1, 1'b1, DB);
    check_lvl("valid after ack+set", data_valid, 1'b1);
    ack_clear();
    idle(4);

    // Reset during data bit 4, then a clean frame.
    send_frame(8'h5A, 1'b1, 1'b0, 4);
    @(posedge fsm_clk); #1;
    fsm_rst_n = 1'b0;
    #1;
    check_all_zero("midframe reset");
    rxd_sync = 1'b1;
    repeat (4) @(posedge fsm_clk);
    check_lvl("events before reset consumed", exp_q.size() == 0, 1'b1);
    exp_q.delete();
    m_valid = 1'b0;
    #1 fsm_rst_n = 1'b1;
    idle(20);
    send_frame(8'hFF, 1'b1, 1'b0, DB);
    check_lvl("valid after FF", data_valid, 1'b1);
    ack_clear();
    idle(4);

    // Break: line low for three back-to-back frame attempts.
    drive_tick(1'b0, 1'b0);
    t0 = tick_total;
    for (int i = 0; i < 3; i++) expect_frame(t0 + i * (FRAME + 1), '0, 1'b0, 1'b0, DB);
    repeat (3 * (FRAME + 1) - 1) drive_tick(1'b0, 1'b0);
    check_lvl("valid during break", data_valid, 1'b0);
    idle(20);
    send_frame(8'hC3, 1'b1, 1'b0, DB);
    check_lvl("valid after break", data_valid, 1'b1);
    ack_clear();

    // Randomized frames, gaps, stop bits and acks.
    for (int i = 0; i < 10; i++) begin
      d  = DB'($urandom);
      st = ($urandom_range(0, 5) != 0);
      idle($urandom_range(0, 12));
      send_frame(d, st, 1'b0, DB);
      check_lvl("random valid level", data_valid, m_valid);
      if ($urandom_range(0, 1) == 1) ack_clear();
    end

    idle(20);
    check_lvl("all expected events seen", exp_q.size() == 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
